beat_scheduler: RTL and testbench

BEAT_SCHEDULER -- requirements
Module: beat_scheduler

---
 rtl/bpm_pkg.sv | 18 +
 rtl/seq_divider.sv | 60 ++++++
 rtl/beat_scheduler.sv | 139 +++++++++++++
 tb/tb_beat_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpm_pkg.sv
// Shared tempo-scheduler types: FSM states, accepted BPM range and period width.
package bpm_pkg;

    localparam int PERIOD_W = 32;
    localparam int MIN_BPM  = 30;
    localparam int MAX_BPM  = 300;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DIV,
        RUN
    } sched_state_t;

    function automatic logic bpm_in_range(input logic [PERIOD_W-1:0] bpm);
        return (bpm >= PERIOD_W'(MIN_BPM)) && (bpm <= PERIOD_W'(MAX_BPM));
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; done pulses 33 cycles after start.
// No backpressure: start is ignored while busy, quotient is held until the next start.
module seq_divider
    import bpm_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [PERIOD_W-1:0] dividend,
    input  logic [PERIOD_W-1:0] divisor,
    output logic                busy,
    output logic                done,
    output logic [PERIOD_W-1:0] quotient
);

    localparam int STEP_W = $clog2(PERIOD_W);

    logic [PERIOD_W-1:0] rem;
    logic [PERIOD_W-1:0] dvsr;
    logic [STEP_W-1:0]   step;
    logic [PERIOD_W:0]   rem_sh;
    logic [PERIOD_W:0]   trial;
    logic                fits;

    // quotient doubles as the dividend shift register; its MSB feeds the remainder
    always_comb begin
        rem_sh = {rem, quotient[PERIOD_W-1]};
        trial  = rem_sh - {1'b0, dvsr};
        fits   = ~trial[PERIOD_W];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem      <= '0;
            dvsr     <= '0;
            step     <= '0;
            quotient <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                rem      <= '0;
                dvsr     <= divisor;
                quotient <= dividend;
                step     <= '0;
                busy     <= 1'b1;
            end else if (busy) begin
                rem      <= fits ? trial[PERIOD_W-1:0] : rem_sh[PERIOD_W-1:0];
                quotient <= {quotient[PERIOD_W-2:0], fits};
                step     <= step + STEP_W'(1);
                if (step == STEP_W'(PERIOD_W - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/beat_scheduler.sv
// Beat-pulse scheduler: turns a BPM estimate into a periodic pulse, re-phased by detected beats.
// Latency bpm_valid -> locked/pulse/period is 35 cycles; no backpressure, BPM arriving mid-divide is held (latest wins).
module beat_scheduler
    import bpm_pkg::*;
#(
    parameter int CLOCK_FREQ   = 25_000_000,
    parameter int BPM_WIDTH    = 16,
    parameter int PULSE_CYCLES = 2_500_000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [BPM_WIDTH-1:0] bpm_val,
    input  logic                 bpm_valid,
    input  logic                 beat_in,
    input  logic                 enable,
    output logic                 beat_pulse,
    output logic                 locked,
    output logic [PERIOD_W-1:0]  period_cycles,
    output logic [7:0]           beat_count
);

    localparam logic [PERIOD_W-1:0] DIVIDEND  = PERIOD_W'(64'd60 * 64'(CLOCK_FREQ));
    localparam logic [PERIOD_W-1:0] PULSE_MAX = PERIOD_W'(PULSE_CYCLES);

    sched_state_t          state;
    logic [PERIOD_W-1:0]   counter;
    logic                  start_q;
    logic [BPM_WIDTH-1:0]  start_bpm;
    logic                  pend_vld;
    logic [BPM_WIDTH-1:0]  pend_bpm;
    logic                  want;

    logic                  div_start;
    logic [PERIOD_W-1:0]   div_divisor;
    logic                  div_busy;
    logic                  div_done;
    logic [PERIOD_W-1:0]   div_quo;

    logic                  bpm_zero;
    logic                  bpm_ok;
    logic                  pend_go;
    logic                  div_engaged;
    logic [PERIOD_W-1:0]   half;
    logic [PERIOD_W-1:0]   pulse_lim;
    logic                  wrap;
    logic                  beat_hit;

    always_comb begin
        bpm_zero    = bpm_valid && (bpm_val == '0);
        bpm_ok      = bpm_valid && bpm_in_range(PERIOD_W'(bpm_val));
        // a held BPM launches in the same cycle the previous result comes out
        pend_go     = div_done && pend_vld;
        div_start   = start_q || pend_go;
        div_divisor = start_q ? PERIOD_W'(start_bpm) : PERIOD_W'(pend_bpm);
        div_engaged = start_q || div_busy || pend_go;
        half        = period_cycles >> 1;
        pulse_lim   = (PULSE_MAX < half) ? PULSE_MAX : half;
        wrap        = counter >= (period_cycles - PERIOD_W'(1));
        beat_hit    = beat_in && (counter >= half);
    end

    assign beat_pulse = (state == RUN) && enable && (counter < pulse_lim);

    seq_divider u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start),
        .dividend (DIVIDEND),
        .divisor  (div_divisor),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            counter       <= '0;
            locked        <= 1'b0;
            period_cycles <= '0;
            beat_count    <= '0;
            start_q       <= 1'b0;
            start_bpm     <= '0;
            pend_vld      <= 1'b0;
            pend_bpm      <= '0;
            want          <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (div_done) begin
                want <= pend_vld;
            end
            if (pend_go) begin
                pend_vld <= 1'b0;
            end

            // wrap and early beat coinciding count as one beat
            if (state == RUN) begin
                if (wrap || beat_hit) begin
                    counter    <= '0;
                    beat_count <= beat_count + 8'd1;
                end else begin
                    counter <= counter + PERIOD_W'(1);
                end
            end

            if (bpm_zero) begin
                state    <= IDLE;
                locked   <= 1'b0;
                counter  <= '0;
                pend_vld <= 1'b0;
                want     <= 1'b0;
            end else begin
                // results of divides launched before a stop are discarded via want
                if (div_done && want) begin
                    period_cycles <= div_quo;
                    locked        <= 1'b1;
                    state         <= RUN;
                    if (state != RUN) begin
                        counter <= '0;
                    end
                end
                if (bpm_ok) begin
                    if (div_engaged) begin
                        pend_vld <= 1'b1;
                        pend_bpm <= bpm_val;
                    end else begin
                        start_q   <= 1'b1;
                        start_bpm <= bpm_val;
                        want      <= 1'b1;
                    end
                    if (state == IDLE) begin
                        state <= WAIT_DIV;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_beat_scheduler.sv
// Self-checking bench for beat_scheduler: directed scenarios plus a randomized run against a timing model.
module tb_beat_scheduler;

    localparam int CF = 1000;
    localparam int PC = 100;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] bpm_val = '0;
    logic        bpm_valid = 1'b0;
    logic        beat_in = 1'b0;
    logic        enable = 1'b1;
    logic        beat_pulse, locked;
    logic [31:0] period_cycles;
    logic [7:0]  beat_count;
    logic        beat_pulse2, locked2;
    logic [31:0] period2;
    logic [7:0]  count2;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    beat_scheduler #(.CLOCK_FREQ(CF), .BPM_WIDTH(16), .PULSE_CYCLES(PC)) dut (
        .clk(clk), .reset_n(reset_n), .bpm_val(bpm_val), .bpm_valid(bpm_valid),
        .beat_in(beat_in), .enable(enable), .beat_pulse(beat_pulse), .locked(locked),
        .period_cycles(period_cycles), .beat_count(beat_count));

    beat_scheduler #(.CLOCK_FREQ(CF), .BPM_WIDTH(16), .PULSE_CYCLES(200)) dut2 (
        .clk(clk), .reset_n(reset_n), .bpm_val(bpm_val), .bpm_valid(bpm_valid),
        .beat_in(beat_in), .enable(enable), .beat_pulse(beat_pulse2), .locked(locked2),
        .period_cycles(period2), .beat_count(count2));

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic at(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic strobe_bpm(input int v, output int t0);
        bpm_val = 16'(v);
        bpm_valid = 1'b1;
        t0 = cyc;
        @(negedge clk);
        bpm_valid = 1'b0;
        bpm_val = '0;
    endtask

    task automatic strobe_beat();
        beat_in = 1'b1;
        @(negedge clk);
        beat_in = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bpm_valid = 1'b0;
        bpm_val = '0;
        beat_in = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %0b want 0", locked); end
        vectors++; if (beat_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_pulse: got %0b want 0", beat_pulse); end
        vectors++; if (period_cycles !== 32'd0) begin miscompares++; $display("FAIL reset_period: got %0d want 0", period_cycles); end
        vectors++; if (beat_count !== 8'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", beat_count); end
    endtask

    task automatic test_lock();
        int t0, hi, shape_err;
        do_reset();
        strobe_bpm(120, t0);
        at(t0 + 34);
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL lock_early: locked=%0b want 0 at cycle 34", locked); end
        at(t0 + 35);
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL lock_35: locked=%0b want 1", locked); end
        vectors++; if (period_cycles !== 32'd500) begin miscompares++; $display("FAIL lock_period: got %0d want 500", period_cycles); end
        vectors++; if (beat_pulse !== 1'b1) begin miscompares++; $display("FAIL lock_pulse: got %0b want 1", beat_pulse); end
        hi = 0;
        shape_err = 0;
        for (int i = 0; i < 500; i++) begin
            at(t0 + 35 + i);
            if (beat_pulse !== (i < 100)) shape_err++;
            if (beat_pulse === 1'b1) hi++;
        end
        vectors++; if (hi != 100) begin miscompares++; $display("FAIL pulse_high: got %0d cycles want 100", hi); end
        vectors++; if (shape_err != 0) begin miscompares++; $display("FAIL pulse_shape: %0d bad cycles want 0", shape_err); end
        vectors++; if (beat_count !== 8'd0) begin miscompares++; $display("FAIL count_pre_wrap: got %0d want 0", beat_count); end
        at(t0 + 535);
        vectors++; if (beat_count !== 8'd1) begin miscompares++; $display("FAIL count_wrap1: got %0d want 1", beat_count); end
        at(t0 + 1035);
        vectors++; if (beat_count !== 8'd2) begin miscompares++; $display("FAIL count_wrap2: got %0d want 2", beat_count); end
    endtask

    task automatic test_retune();
        int t0, t1, shape_err;
        do_reset();
        strobe_bpm(120, t0);
        at(t0 + 45);
        strobe_bpm(60, t1);
        shape_err = 0;
        for (int j = 1; j <= 120; j++) begin
            at(t1 + j);
            if (beat_pulse !== ((10 + j) < 100)) shape_err++;
            if (j == 34) begin
                vectors++; if (period_cycles !== 32'd500) begin miscompares++; $display("FAIL retune_old: got %0d want 500", period_cycles); end
            end
            if (j == 35) begin
                vectors++; if (period_cycles !== 32'd1000) begin miscompares++; $display("FAIL retune_new: got %0d want 1000", period_cycles); end
            end
        end
        vectors++; if (shape_err != 0) begin miscompares++; $display("FAIL retune_glitch: %0d bad cycles want 0", shape_err); end
        at(t1 + 989);
        vectors++; if (beat_count !== 8'd0) begin miscompares++; $display("FAIL retune_prewrap: got %0d want 0", beat_count); end
        at(t1 + 990);
        vectors++; if (beat_count !== 8'd1) begin miscompares++; $display("FAIL retune_wrap: got %0d want 1", beat_count); end
        vectors++; if (beat_pulse !== 1'b1) begin miscompares++; $display("FAIL retune_wrap_pulse: got %0b want 1", beat_pulse); end
    endtask

    task automatic test_beat_in();
        int t0;
        do_reset();
        strobe_bpm(120, t0);
        at(t0 + 135);
        strobe_beat();
        vectors++; if (beat_pulse !== 1'b0) begin miscompares++; $display("FAIL beat_early_pulse: got %0b want 0", beat_pulse); end
        vectors++; if (beat_count !== 8'd0) begin miscompares++; $display("FAIL beat_early_count: got %0d want 0", beat_count); end
        at(t0 + 435);
        strobe_beat();
        vectors++; if (beat_pulse !== 1'b1) begin miscompares++; $display("FAIL beat_late_pulse: got %0b want 1", beat_pulse); end
        vectors++; if (beat_count !== 8'd1) begin miscompares++; $display("FAIL beat_late_count: got %0d want 1", beat_count); end
        at(t0 + 935);
        vectors++; if (beat_count !== 8'd1) begin miscompares++; $display("FAIL beat_wrap_before: got %0d want 1", beat_count); end
        strobe_beat();
        vectors++; if (beat_count !== 8'd2) begin miscompares++; $display("FAIL beat_on_wrap: got %0d want 2", beat_count); end
        at(t0 + 936 + 249);
        strobe_beat();
        vectors++; if (beat_pulse !== 1'b0) begin miscompares++; $display("FAIL beat_half_minus1: pulse %0b want 0", beat_pulse); end
        strobe_beat();
        vectors++; if (beat_pulse !== 1'b1) begin miscompares++; $display("FAIL beat_at_half: pulse %0b want 1", beat_pulse); end
        vectors++; if (beat_count !== 8'd3) begin miscompares++; $display("FAIL beat_at_half_count: got %0d want 3", beat_count); end
    endtask

    task automatic test_range_stop();
        int t;
        do_reset();
        strobe_bpm(29, t);
        at(t + 40);
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL bpm29_locked: got %0b want 0", locked); end
        strobe_bpm(30, t);
        at(t + 35);
        vectors++; if (period_cycles !== 32'd2000) begin miscompares++; $display("FAIL bpm30_period: got %0d want 2000", period_cycles); end
        strobe_bpm(500, t);
        at(t + 40);
        vectors++; if (period_cycles !== 32'd2000) begin miscompares++; $display("FAIL bpm500_ignored: got %0d want 2000", period_cycles); end
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL bpm500_locked: got %0b want 1", locked); end
        strobe_bpm(0, t);
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL stop_locked: got %0b want 0", locked); end
        vectors++; if (beat_pulse !== 1'b0) begin miscompares++; $display("FAIL stop_pulse: got %0b want 0", beat_pulse); end
        vectors++; if (period_cycles !== 32'd2000) begin miscompares++; $display("FAIL stop_period_held: got %0d want 2000", period_cycles); end
        strobe_beat();
        strobe_bpm(301, t);
        at(t + 40);
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL bpm301_locked: got %0b want 0", locked); end
        vectors++; if (beat_count !== 8'd0) begin miscompares++; $display("FAIL idle_beat_count: got %0d want 0", beat_count); end
    endtask

    task automatic test_pending();
        int t0, tx, hi, shape_err;
        do_reset();
        strobe_bpm(120, t0);
        at(t0 + 5);
        strobe_bpm(60, tx);
        at(t0 + 10);
        strobe_bpm(240, tx);
        at(t0 + 35);
        vectors++; if (period_cycles !== 32'd500) begin miscompares++; $display("FAIL pend_first: got %0d want 500", period_cycles); end
        at(t0 + 67);
        vectors++; if (period_cycles !== 32'd500) begin miscompares++; $display("FAIL pend_hold: got %0d want 500", period_cycles); end
        at(t0 + 68);
        vectors++; if (period_cycles !== 32'd250) begin miscompares++; $display("FAIL pend_second: got %0d want 250", period_cycles); end
        at(t0 + 110);
        vectors++; if (period_cycles !== 32'd250) begin miscompares++; $display("FAIL pend_latest: got %0d want 250", period_cycles); end
        do_reset();
        strobe_bpm(300, t0);
        at(t0 + 35);
        vectors++; if (period2 !== 32'd200) begin miscompares++; $display("FAIL p200_period: got %0d want 200", period2); end
        hi = 0;
        shape_err = 0;
        for (int i = 0; i < 200; i++) begin
            at(t0 + 35 + i);
            if (beat_pulse2 !== (i < 100)) shape_err++;
            if (beat_pulse2 === 1'b1) hi++;
        end
        vectors++; if (hi != 100) begin miscompares++; $display("FAIL p200_width: got %0d want 100", hi); end
        vectors++; if (shape_err != 0) begin miscompares++; $display("FAIL p200_shape: %0d bad cycles want 0", shape_err); end
    endtask

    task automatic test_reset_mid_divide();
        int t0, t1, t2;
        do_reset();
        strobe_bpm(120, t0);
        at(t0 + 535);
        vectors++; if (beat_count !== 8'd1) begin miscompares++; $display("FAIL rst_pre_count: got %0d want 1", beat_count); end
        strobe_bpm(240, t1);
        at(t1 + 10);
        reset_n = 1'b0;
        #1;
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL rst_async_locked: got %0b want 0", locked); end
        vectors++; if (beat_pulse !== 1'b0) begin miscompares++; $display("FAIL rst_async_pulse: got %0b want 0", beat_pulse); end
        vectors++; if (period_cycles !== 32'd0) begin miscompares++; $display("FAIL rst_async_period: got %0d want 0", period_cycles); end
        vectors++; if (beat_count !== 8'd0) begin miscompares++; $display("FAIL rst_async_count: got %0d want 0", beat_count); end
        @(negedge clk);
        reset_n = 1'b1;
        t2 = cyc;
        at(t2 + 60);
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL rst_no_lock: got %0b want 0", locked); end
        vectors++; if (period_cycles !== 32'd0) begin miscompares++; $display("FAIL rst_no_period: got %0d want 0", period_cycles); end
    endtask

    // Model tracks when each divide finishes as a cycle timestamp rather than divider state.
    task automatic test_random();
        int  m_period, m_phase, m_beats, done_at, div_bpm, pend_bpm, load_bpm, v, lim;
        bit  m_locked, m_running, m_waiting, keep, pend, load_keep, done_now, exp_pulse;
        do_reset();
        m_period = 0; m_phase = 0; m_beats = 0; done_at = -1000; div_bpm = 0; pend_bpm = 0;
        m_locked = 0; m_running = 0; m_waiting = 0; keep = 0; pend = 0;
        for (int t = 0; t < 3000; t++) begin
            lim = (PC < m_period / 2) ? PC : m_period / 2;
            exp_pulse = m_running && enable && (m_phase < lim);
            vectors++; if (locked !== m_locked) begin miscompares++; $display("FAIL rand_locked t=%0d: got %0b want %0b", t, locked, m_locked); end
            vectors++; if (period_cycles !== 32'(m_period)) begin miscompares++; $display("FAIL rand_period t=%0d: got %0d want %0d", t, period_cycles, m_period); end
            vectors++; if (beat_count !== 8'(m_beats)) begin miscompares++; $display("FAIL rand_count t=%0d: got %0d want %0d", t, beat_count, m_beats % 256); end
            vectors++; if (beat_pulse !== exp_pulse) begin miscompares++; $display("FAIL rand_pulse t=%0d: got %0b want %0b", t, beat_pulse, exp_pulse); end

            bpm_valid = ($urandom_range(0, 89) == 0);
            case ($urandom_range(0, 9))
                0: v = 0;
                1: v = 29;
                2: v = 30;
                3: v = 300;
                4: v = 301;
                5: v = 500;
                6: v = 60;
                7: v = 120;
                default: v = $urandom_range(30, 300);
            endcase
            bpm_val = bpm_valid ? 16'(v) : 16'd0;
            beat_in = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 49) == 0) enable = ~enable;

            done_now = (done_at == t);
            if (m_running) begin
                if (m_phase >= m_period - 1 || (beat_in && m_phase >= m_period / 2)) begin
                    m_phase = 0;
                    m_beats = m_beats + 1;
                end else begin
                    m_phase = m_phase + 1;
                end
            end
            load_keep = 0;
            load_bpm = div_bpm;
            if (done_now) begin
                load_keep = keep;
                if (pend) begin
                    done_at = t + 33;
                    div_bpm = pend_bpm;
                    keep = 1;
                    pend = 0;
                end else begin
                    keep = 0;
                end
            end
            if (bpm_valid && bpm_val == 0) begin
                m_running = 0; m_waiting = 0; m_locked = 0; m_phase = 0; pend = 0; keep = 0;
            end else begin
                if (done_now && load_keep) begin
                    m_period = 60 * CF / load_bpm;
                    m_locked = 1;
                    if (!m_running) m_phase = 0;
                    m_running = 1;
                    m_waiting = 0;
                end
                if (bpm_valid && bpm_val >= 30 && bpm_val <= 300) begin
                    if (t >= done_at - 33 && t < done_at) begin
                        pend = 1;
                        pend_bpm = int'(bpm_val);
                    end else begin
                        done_at = t + 34;
                        div_bpm = int'(bpm_val);
                        keep = 1;
                    end
                    if (!m_running) m_waiting = 1;
                end
            end
            @(negedge clk);
        end
        bpm_valid = 1'b0;
        beat_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_retune();
        test_beat_in();
        test_range_stop();
        test_pending();
        test_reset_mid_divide();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
